// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive types, frame constants and parameter checks
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    localparam int DATA_BITS       = 8;
    localparam int CNT_W           = 4;
    localparam int FRAME_BITS      = DATA_BITS + 2;
    localparam int FRAME_BITS_PAR  = DATA_BITS + 3;

    // Oversampling must be a power of two that fits the 4-bit cycle counter.
    function automatic bit os_legal(input int os);
        return (os == 1) || (os == 2) || (os == 4) || (os == 8) || (os == 16);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for an asynchronous single-bit input
`timescale 1ns/1ps
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/receiver.sv
// rtl/receiver.sv - UART serial receiver: start/data/parity/stop deframing into RBR
`timescale 1ns/1ps
module receiver #(
    parameter int OS        = 1,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic       bclk,
    input  logic       rst,
    input  logic       rx_data,
    input  logic       rx_ack,
    output logic [7:0] RBR,
    output logic       rx_status,
    output logic       framing_err,
    output logic       parity_err,
    output logic       overrun_err
);
    import uart_pkg::*;

    if (!os_legal(OS)) begin : g_os_check
        $error("receiver: OS must be 1, 2, 4, 8 or 16");
    end

    localparam int               H         = OS / 2;
    localparam logic [CNT_W-1:0] HALF_LAST = (H > 0) ? CNT_W'(H - 1) : '0;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OS - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    logic rx_s;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (bclk),
        .rst (rst),
        .d   (rx_data),
        .q   (rx_s)
    );

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             frm_perr_q, frm_perr_d;
    logic             stop_q, stop_d;
    logic             done_q, done_d;
    logic [7:0]       rbr_q, rbr_d;
    logic             status_q, status_d;
    logic             ferr_q, ferr_d;
    logic             perr_q, perr_d;
    logic             ovr_q, ovr_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        frm_perr_d = frm_perr_q;
        stop_d     = stop_q;
        done_d     = 1'b0;
        rbr_d      = rbr_q;
        status_d   = status_q;
        ferr_d     = ferr_q;
        perr_d     = perr_q;
        ovr_d      = ovr_q;

        // With OS=1 the detection cycle doubles as the start-bit sample.
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    cnt_d      = '0;
                    bit_d      = '0;
                    frm_perr_d = 1'b0;
                    state_d    = (OS == 1) ? ST_DATA : ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == LAST_BIT) begin
                        state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d      = '0;
                    frm_perr_d = (^shift_q) ^ rx_s;
                    state_d    = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    stop_d  = rx_s;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Completion lands one cycle after the stop sample so the FSM can already re-arm.
        if (done_q) begin
            if (!status_q || rx_ack) begin
                rbr_d    = shift_q;
                ferr_d   = ~stop_q;
                perr_d   = frm_perr_q;
                status_d = 1'b1;
                if (rx_ack) begin
                    ovr_d = 1'b0;
                end
            end else begin
                ovr_d = 1'b1;
            end
        end else if (rx_ack) begin
            status_d = 1'b0;
            ovr_d    = 1'b0;
        end
    end

    always_ff @(posedge bclk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            frm_perr_q <= 1'b0;
            stop_q     <= 1'b1;
            done_q     <= 1'b0;
            rbr_q      <= '0;
            status_q   <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            frm_perr_q <= frm_perr_d;
            stop_q     <= stop_d;
            done_q     <= done_d;
            rbr_q      <= rbr_d;
            status_q   <= status_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign RBR         = rbr_q;
    assign rx_status   = status_q;
    assign framing_err = ferr_q;
    assign parity_err  = perr_q;
    assign overrun_err = ovr_q;

endmodule

// File: tb/tb_receiver.sv
// tb/tb_receiver.sv - directed self-checking bench for receiver (OS=1, OS=1 with parity, OS=16)
`timescale 1ns/1ps
module tb_receiver;

    logic bclk = 1'b0;
    always #5 bclk = ~bclk;

    logic       rst;
    logic       rx_a, rx_p, rx_o;
    logic       ack_a, ack_p, ack_o;
    logic [7:0] rbr_a, rbr_p, rbr_o;
    logic       st_a, fe_a, pe_a, ov_a;
    logic       st_p, fe_p, pe_p, ov_p;
    logic       st_o, fe_o, pe_o, ov_o;

    int total = 0;
    int bad   = 0;

    receiver #(.OS(1), .PARITY_EN(1'b0)) u_a (
        .bclk(bclk), .rst(rst), .rx_data(rx_a), .rx_ack(ack_a), .RBR(rbr_a),
        .rx_status(st_a), .framing_err(fe_a), .parity_err(pe_a), .overrun_err(ov_a)
    );

    receiver #(.OS(1), .PARITY_EN(1'b1)) u_p (
        .bclk(bclk), .rst(rst), .rx_data(rx_p), .rx_ack(ack_p), .RBR(rbr_p),
        .rx_status(st_p), .framing_err(fe_p), .parity_err(pe_p), .overrun_err(ov_p)
    );

    receiver #(.OS(16), .PARITY_EN(1'b0)) u_o (
        .bclk(bclk), .rst(rst), .rx_data(rx_o), .rx_ack(ack_o), .RBR(rbr_o),
        .rx_status(st_o), .framing_err(fe_o), .parity_err(pe_o), .overrun_err(ov_o)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge bclk);
        #1;
    endtask

    task automatic drive(input int which, input logic v);
        case (which)
            0:       rx_a = v;
            1:       rx_p = v;
            default: rx_o = v;
        endcase
    endtask

    task automatic ack(input int which);
        case (which)
            0:       ack_a = 1'b1;
            1:       ack_p = 1'b1;
            default: ack_o = 1'b1;
        endcase
        tick();
        ack_a = 1'b0;
        ack_p = 1'b0;
        ack_o = 1'b0;
    endtask

    // Frame bits go out LSB first starting with the start bit; each bit is held for os edges.
    task automatic send(input int which, input logic [7:0] b, input bit par_en,
                        input logic par, input logic stp, input int os);
        logic [10:0] bits;
        int          n;
        if (par_en) begin
            bits = {stp, par, b, 1'b0};
            n    = 11;
        end else begin
            bits = {1'b1, stp, b, 1'b0};
            n    = 10;
        end
        for (int i = 0; i < n; i++) begin
            drive(which, bits[i]);
            repeat (os) tick();
        end
        drive(which, 1'b1);
    endtask

    initial begin
        logic [7:0] part;
        rst   = 1'b1;
        rx_a  = 1'b1; rx_p = 1'b1; rx_o = 1'b1;
        ack_a = 1'b0; ack_p = 1'b0; ack_o = 1'b0;
        repeat (3) tick();
        chk("reset_rbr", rbr_a, 8'h00);
        chk("reset_flags", {4'h0, st_a, fe_a, pe_a, ov_a}, 8'h00);
        chk("reset_flags_o", {4'h0, st_o, fe_o, pe_o, ov_o}, 8'h00);
        rst = 1'b0;
        tick();

        // Single frame, exact latency: status rises 12 edges after the start bit.
        send(0, 8'b01101100, 1'b0, 1'b0, 1'b1, 1);
        tick(); tick();
        chk("latency_pre", {7'h0, st_a}, 8'h00);
        tick();
        chk("latency_status", {7'h0, st_a}, 8'h01);
        chk("first_rbr", rbr_a, 8'h6C);
        chk("first_errs", {5'h0, fe_a, pe_a, ov_a}, 8'h00);
        ack(0);
        chk("ack_clears_status", {7'h0, st_a}, 8'h00);

        // Back-to-back frames with an ack between them.
        send(0, 8'h6C, 1'b0, 1'b0, 1'b1, 1);
        fork
            send(0, 8'h6D, 1'b0, 1'b0, 1'b1, 1);
            begin
                tick(); tick(); tick();
                chk("b2b_first_rbr", rbr_a, 8'h6C);
                chk("b2b_first_status", {7'h0, st_a}, 8'h01);
                ack(0);
                chk("b2b_ack", {7'h0, st_a}, 8'h00);
            end
        join
        tick(); tick(); tick();
        chk("b2b_second_rbr", rbr_a, 8'h6D);
        chk("b2b_second_flags", {6'h0, st_a, ov_a}, 8'h02);
        ack(0);

        // Overrun: second frame dropped while RBR is unread.
        send(0, 8'h6C, 1'b0, 1'b0, 1'b1, 1);
        tick(); tick(); tick();
        send(0, 8'h6D, 1'b0, 1'b0, 1'b1, 1);
        tick(); tick(); tick();
        chk("ovr_rbr_held", rbr_a, 8'h6C);
        chk("ovr_flags", {6'h0, st_a, ov_a}, 8'h03);
        ack(0);
        chk("ovr_ack_clears", {6'h0, st_a, ov_a}, 8'h00);
        chk("ovr_rbr_after_ack", rbr_a, 8'h6C);

        // Framing error, then a good frame clears it.
        send(0, 8'h3C, 1'b0, 1'b0, 1'b0, 1);
        tick(); tick(); tick();
        chk("ferr_rbr", rbr_a, 8'h3C);
        chk("ferr_flags", {6'h0, st_a, fe_a}, 8'h03);
        ack(0);
        send(0, 8'h55, 1'b0, 1'b0, 1'b1, 1);
        tick(); tick(); tick();
        chk("ferr_clear_rbr", rbr_a, 8'h55);
        chk("ferr_clear_flags", {5'h0, st_a, fe_a, pe_a}, 8'h04);

        // Even parity: A5 has four ones, so the correct parity bit is 0.
        send(1, 8'hA5, 1'b1, 1'b0, 1'b1, 1);
        tick(); tick();
        chk("par_latency_pre", {7'h0, st_p}, 8'h00);
        tick();
        chk("par_good_rbr", rbr_p, 8'hA5);
        chk("par_good_flags", {5'h0, st_p, fe_p, pe_p}, 8'h04);
        ack(1);
        send(1, 8'hA5, 1'b1, 1'b1, 1'b1, 1);
        tick(); tick(); tick();
        chk("par_bad_rbr", rbr_p, 8'hA5);
        chk("par_bad_flags", {5'h0, st_p, fe_p, pe_p}, 8'h05);

        // OS=16: a short low glitch is rejected at the mid-start sample.
        rx_o = 1'b0;
        repeat (3) tick();
        rx_o = 1'b1;
        repeat (40) tick();
        chk("glitch_no_status", {7'h0, st_o}, 8'h00);
        send(2, 8'h96, 1'b0, 1'b0, 1'b1, 16);
        repeat (3) tick();
        chk("os16_rbr", rbr_o, 8'h96);
        chk("os16_flags", {5'h0, st_o, fe_o, ov_o}, 8'h04);
        ack(2);

        // Reset during data bit 4 abandons the frame.
        part = 8'hE7;
        drive(2, 1'b0);
        repeat (16) tick();
        for (int i = 0; i < 4; i++) begin
            drive(2, part[i]);
            repeat (16) tick();
        end
        drive(2, part[4]);
        repeat (8) tick();
        rst = 1'b1;
        tick(); tick();
        chk("midrst_rbr_o", rbr_o, 8'h00);
        chk("midrst_flags_o", {4'h0, st_o, fe_o, pe_o, ov_o}, 8'h00);
        chk("midrst_rbr_a", rbr_a, 8'h00);
        rx_o = 1'b1;
        tick();
        rst = 1'b0;
        repeat (200) tick();
        chk("midrst_no_ghost", {7'h0, st_o}, 8'h00);
        send(2, 8'hC3, 1'b0, 1'b0, 1'b1, 16);
        repeat (3) tick();
        chk("post_rst_rbr", rbr_o, 8'hC3);
        chk("post_rst_flags", {4'h0, st_o, fe_o, pe_o, ov_o}, 8'h08);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/receiver.md
# receiver

Serial receive stage of the UART, the direct counterpart of the transmitter: it deserialises the `tx_data` line format (idle high, start bit 0, 8 data bits LSB first, optional even parity, 1 stop bit) back into a byte. It sits downstream of the transmitter, in loopback or on the external RX pin, and presents the byte in `RBR` with a ready flag and error flags to the register/bus interface.

## Interface
- `OS`, 1: `bclk` cycles per bit; legal values 1, 2, 4, 8, 16. Use 1 when paired with the transmitter on the same `bclk`.
- `PARITY_EN`, 0: 1 means an even-parity bit follows the data bits.
- `bclk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  1  serial input, asynchronous to `bclk`.
- `rx_ack`  in  1  one-cycle pulse: the consumer has read `RBR`; clears `rx_status` and `overrun_err`.
- `RBR`  out  8  receive buffer register; holds the last accepted byte.
- `rx_status`  out  1  data ready; 1 while `RBR` holds an unread byte.
- `framing_err`  out  1  stop bit of the byte in `RBR` was sampled as 0.
- `parity_err`  out  1  parity mismatch on the byte in `RBR`; held at 0 when `PARITY_EN`=0.
- `overrun_err`  out  1  sticky: a complete frame was dropped because `RBR` was unread.

## Operation
- `rx_data` passes through a 2-flop synchronizer. Both flops reset to 1 (idle line). Its output `rx_s` is the only line signal the FSM uses.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: when `rx_s`=0, that cycle is the detection cycle. Go to START and clear the cycle counter.
- Sample point k lies at detection + H + k·OS cycles, with H = OS/2 (integer division) and k = 0 for the start bit, 1–8 for the data bits, 9 for parity, and 9 or 10 for the stop bit.
- START, OS=1: the detection cycle is the start sample; go straight to DATA.
- START, OS>1: at sample 0, if `rx_s`=1 treat the event as a glitch and return to IDLE with no flags changed. Otherwise go to DATA.
- DATA: shift `rx_s` into bit index 0..7 (LSB first). After bit 7, go to PARITY if `PARITY_EN`=1, else to STOP.
- PARITY: compute perr = (XOR of the 8 data bits) XOR `rx_s`.
- STOP: at the stop sample, complete the frame and go to IDLE. The next cycle can already detect a new start bit, so back-to-back frames are supported.
- Frame completion, applied on the edge after the stop sample:
  - If `rx_status`=0, or `rx_ack`=1 in the same cycle: load `RBR`, set `framing_err` = ~stop, set `parity_err` = perr, set `rx_status`=1.
  - Else: drop the byte, leave `RBR` and the error flags unchanged, set `overrun_err`=1.
- `rx_ack` with no frame completing in that cycle: `rx_status` and `overrun_err` go to 0 on the next edge. `RBR`, `framing_err` and `parity_err` hold.
- A framing error does not stop reception. The FSM returns to IDLE and waits for `rx_s`=0.

## Timing
- Reset: all outputs are 0, `RBR`=8'h00, FSM is in IDLE, synchronizer flops are 1. Reset mid-frame abandons the frame with no flags set.
- Synchronizer latency is 2 cycles. Line low at edge T gives detection at T+2.
- OS=1, `PARITY_EN`=0: data bit i is sampled at T+2+i (i=1..8), the stop bit at T+11, and `rx_status` rises at T+12.
- OS=1, `PARITY_EN`=1: the stop bit is sampled at T+12, and `rx_status` rises at T+13.
- In general, `rx_status` rises 1 cycle after the stop sample.
- `rx_ack` is level-sampled. Holding it high for several cycles behaves like repeated single acks.

## Structure
- Package `uart_pkg` holds:
  - the FSM state enum;
  - localparams for data bits (8) and the frame-length constants;
  - an elaboration-time check that `OS` is a legal value.
- Sub-module `sync_2ff`: a 2-flop synchronizer with a parameterised reset value, instantiated with reset value 1. It can be reused for other async inputs.
- The counter, the shift register and the FSM stay in `receiver`.

## Test plan
- Loopback with the transmitter, OS=1: send 8'b01101100 -> `RBR`=8'h6C, `rx_status`=1 exactly 12 cycles after the start bit reaches `rx_data`, all error flags 0.
- Back-to-back frames 8'h6C then 8'h6D with `rx_ack` pulsed between them -> both bytes received in order, no overrun.
- Two frames without `rx_ack` -> `RBR` stays 8'h6C, `overrun_err`=1. `rx_ack` then clears `rx_status` and `overrun_err`.
- Forced stop bit = 0 -> `framing_err`=1 with the byte loaded. A following good frame after ack clears `framing_err`.
- `PARITY_EN`=1: 8'hA5 with the correct parity bit 0 -> `parity_err`=0. The same byte with parity bit 1 -> `parity_err`=1.
- OS=16: a 3-cycle low glitch on idle -> no `rx_status`. Assert `rst` during data bit 4 of a frame -> all outputs 0, and the next full frame is received correctly.
